// File: rtl/bas_pkg.sv
// Shared definitions for the adder/subtractor sweep checker: FSM encoding and
// sweep size constants.
package bas_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SAMPLE,
        DONE
    } state_t;

    localparam int VECTOR_COUNT = 512;
    localparam int VEC_W        = 9;

    // Vector index layout: {op_a[3:0], op_b[3:0], sub}
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(VECTOR_COUNT - 1);

endpackage

// File: rtl/bas_ref_model.sv
// Combinational golden model of a 4-bit adder/subtractor: sum/difference,
// raw carry-out and signed overflow.
module bas_ref_model (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    output logic [3:0] s,
    output logic       c,
    output logic       v
);

    logic [3:0] b_eff;
    logic [4:0] total;

    // Subtraction is A + ~B + 1, so the carry is the raw adder carry, not a borrow.
    assign b_eff = sub ? ~b : b;
    assign total = {1'b0, a} + {1'b0, b_eff} + {4'b0000, sub};
    assign s     = total[3:0];
    assign c     = total[4];
    assign v     = sub ? ((a[3] != b[3]) & (s[3] != a[3]))
                       : ((a[3] == b[3]) & (s[3] != a[3]));

endmodule

// File: rtl/bas_sweep_checker.sv
// Exhaustive sweep checker for an external 4-bit adder/subtractor: drives all
// 512 operand/mode vectors, compares the results and records the first failure.
module bas_sweep_checker
    import bas_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic       sub,
    input  logic [3:0] res_s,
    input  logic       res_c,
    input  logic       res_v,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic [3:0] fail_a,
    output logic [3:0] fail_b,
    output logic       fail_sub
);

    localparam logic [3:0] LAST_HOLD = 4'(SETTLE_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [VEC_W-1:0] vec_q;
    logic [3:0]       hold_q;
    logic [9:0]       err_q;
    logic [3:0]       fail_a_q;
    logic [3:0]       fail_b_q;
    logic             fail_sub_q;

    logic             load;
    logic             step;
    logic             hold_inc;
    logic             sample_en;

    logic [3:0]       exp_s;
    logic             exp_c;
    logic             exp_v;
    logic             mismatch;

    assign op_a = vec_q[8:5];
    assign op_b = vec_q[4:1];
    assign sub  = vec_q[0];

    bas_ref_model u_ref (
        .a   (op_a),
        .b   (op_b),
        .sub (sub),
        .s   (exp_s),
        .c   (exp_c),
        .v   (exp_v)
    );

    assign mismatch = (res_s != exp_s) || (res_c != exp_c) || (res_v != exp_v);

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step      = 1'b0;
        hold_inc  = 1'b0;
        sample_en = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = HOLD;
                    load    = 1'b1;
                end
            end
            HOLD: begin
                if (hold_q == LAST_HOLD) begin
                    state_d = SAMPLE;
                end else begin
                    hold_inc = 1'b1;
                end
            end
            SAMPLE: begin
                sample_en = 1'b1;
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    state_d = HOLD;
                    step    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The vector index is left at 511 on entering DONE so the last vector stays driven.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            hold_q     <= '0;
            err_q      <= '0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_sub_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                vec_q      <= '0;
                hold_q     <= '0;
                err_q      <= '0;
                fail_a_q   <= '0;
                fail_b_q   <= '0;
                fail_sub_q <= 1'b0;
            end
            if (hold_inc) begin
                hold_q <= hold_q + 4'd1;
            end
            if (step) begin
                vec_q  <= vec_q + VEC_W'(1);
                hold_q <= '0;
            end
            if (sample_en && mismatch) begin
                err_q <= err_q + 10'd1;
                if (err_q == 10'd0) begin
                    fail_a_q   <= op_a;
                    fail_b_q   <= op_b;
                    fail_sub_q <= sub;
                end
            end
        end
    end

    assign busy      = (state_q == HOLD) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign pass      = done && (err_q == 10'd0);
    assign err_count = err_q;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;
    assign fail_sub  = fail_sub_q;

endmodule
